// File: rtl/apb_fifo_regs_pkg.sv
// Shared address map, register bit positions and CTRL layout for apb_fifo_regs.
package apb_fifo_regs_pkg;

    localparam logic [4:0] ADDR_ID           = 5'h00;
    localparam logic [4:0] ADDR_CTRL         = 5'h01;
    localparam logic [4:0] ADDR_STATUS       = 5'h02;
    localparam logic [4:0] ADDR_DATA         = 5'h03;
    localparam logic [4:0] ADDR_SCRATCH_BASE = 5'h10;

    localparam int unsigned CTRL_CLR  = 0;
    localparam int unsigned CTRL_IE   = 1;
    localparam int unsigned ST_EMPTY  = 0;
    localparam int unsigned ST_FULL   = 1;
    localparam int unsigned ST_OVF    = 2;
    localparam int unsigned ST_UNF    = 3;

    typedef struct packed {
        logic [3:0] ws;
        logic [1:0] rsvd;
        logic       ie;
        logic       clr;
    } ctrl_t;

endpackage

// File: rtl/apb_fifo_regs_byte_fifo.sv
// Byte FIFO with power-of-two depth, wrapping pointers and an explicit level count.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign dout    = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (do_push && !clr) mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/apb_fifo_regs.sv
// APB register block: ID, CTRL, STATUS, FIFO data port, 16 scratch registers, wait states.
// Optional PSLVERR output when APB_PSLVERR_EN is defined.
module apb_fifo_regs
    import apb_fifo_regs_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [3:0]  WS_RESET   = 4'd0,
    parameter logic [7:0]  ID_VALUE   = 8'hB8
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PSEL,
    input  logic [4:0] PADDR,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
`ifdef APB_PSLVERR_EN
    output logic       PSLVERR,
`endif
    output logic       irq
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    ctrl_t         ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic [7:0]    scratch_q [16];
    logic [3:0]    wcnt_q, wcnt_d;
    logic          irq_q;

    logic [7:0]    fifo_dout;
    logic [LW-1:0] fifo_level;
    logic          fifo_empty, fifo_full;
    logic          fifo_push, fifo_pop, fifo_clr;

    logic          access, complete, wr, rd;
    logic          sel_id, sel_ctrl, sel_status, sel_data, sel_scr, mapped;
    logic [7:0]    status, rdata;

    assign access     = PSEL & PENABLE;
    assign PREADY     = access ? (wcnt_q == 4'd0) : 1'b1;
    assign complete   = access & PREADY;
    assign wr         = complete & PWRITE;
    assign rd         = complete & ~PWRITE;

    assign sel_id     = (PADDR == ADDR_ID);
    assign sel_ctrl   = (PADDR == ADDR_CTRL);
    assign sel_status = (PADDR == ADDR_STATUS);
    assign sel_data   = (PADDR == ADDR_DATA);
    assign sel_scr    = ((PADDR & 5'h10) == ADDR_SCRATCH_BASE);
    assign mapped     = sel_id | sel_ctrl | sel_status | sel_data | sel_scr;

    assign fifo_push  = wr & sel_data & ~fifo_full;
    assign fifo_pop   = rd & sel_data & ~fifo_empty;
    assign fifo_clr   = wr & sel_ctrl & PWDATA[CTRL_CLR];

    always_comb begin
        status           = '0;
        status[7:4]      = 4'(fifo_level);
        status[ST_UNF]   = unf_q;
        status[ST_OVF]   = ovf_q;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
    end

    always_comb begin
        rdata = 8'h00;
        if (sel_id)          rdata = ID_VALUE;
        else if (sel_ctrl)   rdata = ctrl_q;
        else if (sel_status) rdata = status;
        else if (sel_data)   rdata = fifo_empty ? 8'h00 : fifo_dout;
        else if (sel_scr)    rdata = scratch_q[PADDR[3:0]];
    end

    // Registers only change on the complete cycle, so PRDATA holds through wait states.
    assign PRDATA = access ? rdata : 8'h00;

`ifdef APB_PSLVERR_EN
    assign PSLVERR = complete & (~mapped | (PWRITE & sel_id)
                               | (PWRITE & sel_data & fifo_full)
                               | (~PWRITE & sel_data & fifo_empty));
`endif

    always_comb begin
        wcnt_d = wcnt_q;
        if (PSEL && !PENABLE)              wcnt_d = ctrl_q.ws;
        else if (access && wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (wr && sel_ctrl) begin
            ctrl_d.ws = PWDATA[7:4];
            ctrl_d.ie = PWDATA[CTRL_IE];
        end
        if (wr && sel_status) begin
            if (PWDATA[ST_UNF]) unf_d = 1'b0;
            if (PWDATA[ST_OVF]) ovf_d = 1'b0;
        end
        if (wr && sel_data && fifo_full)  ovf_d = 1'b1;
        if (rd && sel_data && fifo_empty) unf_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ctrl_q <= '{ws: WS_RESET, rsvd: 2'b00, ie: 1'b0, clr: 1'b0};
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wcnt_q <= 4'd0;
            irq_q  <= 1'b0;
            for (int i = 0; i < 16; i++) scratch_q[i] <= 8'h00;
        end else begin
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wcnt_q <= wcnt_d;
            irq_q  <= ctrl_q.ie & ~fifo_empty;
            if (wr && sel_scr) scratch_q[PADDR[3:0]] <= PWDATA;
        end
    end

    assign irq = irq_q;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESETn),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (PWDATA),
        .dout  (fifo_dout),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_apb_fifo_regs.sv
// Directed self-checking bench for apb_fifo_regs (also exercises PSLVERR under APB_PSLVERR_EN).
module tb_apb_fifo_regs;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       PSEL = 1'b0;
    logic [4:0] PADDR = '0;
    logic       PENABLE = 1'b0;
    logic       PWRITE = 1'b0;
    logic [7:0] PWDATA = '0;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       irq;
    logic       err_line;
`ifdef APB_PSLVERR_EN
    logic       PSLVERR;
    assign err_line = PSLVERR;
`else
    assign err_line = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    apb_fifo_regs dut (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .PSEL    (PSEL),
        .PADDR   (PADDR),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
`ifdef APB_PSLVERR_EN
        .PSLVERR (PSLVERR),
`endif
        .irq     (irq)
    );

    always #5 CLK = ~CLK;

    // One APB transfer; returns #1 after the completing edge.
    task automatic apb_xfer(input logic w, input logic [4:0] a, input logic [7:0] d,
                            output logic [7:0] rdat, output int waits, output logic err);
        @(posedge CLK); #1;
        PSEL = 1'b1; PADDR = a; PWRITE = w; PWDATA = d; PENABLE = 1'b0;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        rdat = 8'h00;
        err = 1'b0;
        forever begin
            @(negedge CLK);
            if (PREADY) begin
                rdat = PRDATA;
                err = err_line;
                break;
            end
            waits++;
            if (waits > 20) begin
                checks++; errors++;
                $display("FAIL timeout addr=%h PREADY stuck low, required high within 20 cycles", a);
                break;
            end
        end
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] r; int w; logic e;
        RESETn = 1'b0;
        #12;
        checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL reset_pready got %b want 1", PREADY); end
        checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL reset_prdata got %h want 00", PRDATA); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        @(negedge CLK); RESETn = 1'b1;
        apb_xfer(1'b0, 5'h00, 8'h00, r, w, e);
        checks++; if (r !== 8'hB8) begin errors++; $display("FAIL id_read got %h want b8", r); end
        checks++; if (w !== 0) begin errors++; $display("FAIL id_waits got %0d want 0", w); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL id_irq got %b want 0", irq); end
    endtask

    task automatic test_wait_states();
        logic [7:0] r; int w; logic e;
        apb_xfer(1'b1, 5'h01, 8'h30, r, w, e);
        checks++; if (w !== 0) begin errors++; $display("FAIL ctrl_write_waits got %0d want 0", w); end
        apb_xfer(1'b0, 5'h10, 8'h00, r, w, e);
        checks++; if (w !== 3) begin errors++; $display("FAIL ws3_waits got %0d want 3", w); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL ws3_scratch got %h want 00", r); end
        apb_xfer(1'b0, 5'h01, 8'h00, r, w, e);
        checks++; if (r !== 8'h30) begin errors++; $display("FAIL ctrl_read got %h want 30", r); end
        apb_xfer(1'b1, 5'h01, 8'h00, r, w, e);
        apb_xfer(1'b0, 5'h00, 8'h00, r, w, e);
        checks++; if (w !== 0) begin errors++; $display("FAIL ws0_restored got %0d want 0", w); end
    endtask

    task automatic test_fifo_basic();
        logic [7:0] r; int w; logic e;
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) apb_xfer(1'b1, 5'h03, vals[i], r, w, e);
        apb_xfer(1'b0, 5'h02, 8'h00, r, w, e);
        checks++; if (r !== 8'h30) begin errors++; $display("FAIL status_3 got %h want 30", r); end
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b0, 5'h03, 8'h00, r, w, e);
            checks++;
            if (r !== vals[i]) begin errors++; $display("FAIL pop_%0d got %h want %h", i, r, vals[i]); end
        end
        apb_xfer(1'b0, 5'h02, 8'h00, r, w, e);
        checks++; if (r !== 8'h01) begin errors++; $display("FAIL status_empty got %h want 01", r); end
    endtask

    task automatic test_overflow();
        logic [7:0] r; int w; logic e;
        for (int i = 0; i < 9; i++) begin
            apb_xfer(1'b1, 5'h03, 8'h40 + 8'(i), r, w, e);
`ifdef APB_PSLVERR_EN
            checks++;
            if (e !== (i == 8)) begin errors++; $display("FAIL pslverr_push_%0d got %b want %b", i, e, (i == 8)); end
`endif
        end
        apb_xfer(1'b0, 5'h02, 8'h00, r, w, e);
        checks++; if (r !== 8'h86) begin errors++; $display("FAIL status_ovf got %h want 86", r); end
        apb_xfer(1'b1, 5'h02, 8'h04, r, w, e);
        apb_xfer(1'b0, 5'h02, 8'h00, r, w, e);
        checks++; if (r !== 8'h82) begin errors++; $display("FAIL status_ovf_clr got %h want 82", r); end
        apb_xfer(1'b0, 5'h03, 8'h00, r, w, e);
        checks++; if (r !== 8'h40) begin errors++; $display("FAIL full_head got %h want 40", r); end
        apb_xfer(1'b1, 5'h01, 8'h01, r, w, e);
        apb_xfer(1'b0, 5'h01, 8'h00, r, w, e);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL ctrl_clr_readback got %h want 00", r); end
        apb_xfer(1'b0, 5'h02, 8'h00, r, w, e);
        checks++; if (r !== 8'h01) begin errors++; $display("FAIL status_after_clr got %h want 01", r); end
        apb_xfer(1'b0, 5'h03, 8'h00, r, w, e);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL pop_empty got %h want 00", r); end
`ifdef APB_PSLVERR_EN
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL pslverr_pop_empty got %b want 1", e); end
`endif
        apb_xfer(1'b0, 5'h02, 8'h00, r, w, e);
        checks++; if (r !== 8'h09) begin errors++; $display("FAIL status_unf got %h want 09", r); end
        apb_xfer(1'b1, 5'h02, 8'h08, r, w, e);
        apb_xfer(1'b0, 5'h02, 8'h00, r, w, e);
        checks++; if (r !== 8'h01) begin errors++; $display("FAIL status_unf_clr got %h want 01", r); end
    endtask

    task automatic test_scratch();
        logic [7:0] r; int w; logic e;
        apb_xfer(1'b1, 5'h1F, 8'hA5, r, w, e);
`ifdef APB_PSLVERR_EN
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL pslverr_scratch got %b want 0", e); end
`endif
        apb_xfer(1'b1, 5'h07, 8'hFF, r, w, e);
`ifdef APB_PSLVERR_EN
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL pslverr_unmapped got %b want 1", e); end
`endif
        apb_xfer(1'b1, 5'h00, 8'h55, r, w, e);
        apb_xfer(1'b0, 5'h1F, 8'h00, r, w, e);
        checks++; if (r !== 8'hA5) begin errors++; $display("FAIL scratch_1f got %h want a5", r); end
        apb_xfer(1'b0, 5'h07, 8'h00, r, w, e);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL unmapped_07 got %h want 00", r); end
        apb_xfer(1'b0, 5'h10, 8'h00, r, w, e);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL scratch_10 got %h want 00", r); end
        apb_xfer(1'b0, 5'h00, 8'h00, r, w, e);
        checks++; if (r !== 8'hB8) begin errors++; $display("FAIL id_after_write got %h want b8", r); end
    endtask

    task automatic test_irq_and_reset();
        logic [7:0] r; int w; logic e;
        apb_xfer(1'b1, 5'h01, 8'h02, r, w, e);
        apb_xfer(1'b1, 5'h03, 8'h5A, r, w, e);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_not_yet got %b want 0", irq); end
        @(posedge CLK); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", irq); end
        apb_xfer(1'b0, 5'h03, 8'h00, r, w, e);
        checks++; if (r !== 8'h5A) begin errors++; $display("FAIL irq_pop got %h want 5a", r); end
        @(posedge CLK); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b want 0", irq); end
        apb_xfer(1'b1, 5'h01, 8'h22, r, w, e);
        apb_xfer(1'b1, 5'h03, 8'h77, r, w, e);
        checks++; if (w !== 2) begin errors++; $display("FAIL push_ws2 got %0d want 2", w); end
        @(posedge CLK); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_rst got %b want 1", irq); end
        PSEL = 1'b1; PADDR = 5'h10; PWRITE = 1'b0; PENABLE = 1'b0;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        @(negedge CLK);
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL midwait_pready got %b want 0", PREADY); end
        #2 RESETn = 1'b0;
        #1;
        checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL rst_pready got %b want 1", PREADY); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge CLK); #1;
        RESETn = 1'b1;
        apb_xfer(1'b0, 5'h02, 8'h00, r, w, e);
        checks++; if (r !== 8'h01) begin errors++; $display("FAIL rst_status got %h want 01", r); end
        checks++; if (w !== 0) begin errors++; $display("FAIL rst_ws got %0d want 0", w); end
        apb_xfer(1'b0, 5'h01, 8'h00, r, w, e);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL rst_ctrl got %h want 00", r); end
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_fifo_basic();
        test_overflow();
        test_scratch();
        test_irq_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
